// File: rtl/scan_mux.sv
// -----------------------------------------------------------------------------
// scan_mux -- registered N-channel multiplexer with one-hot select outputs.
//
// Two operating modes:
//   manual (mode_i=0): the channel named by sel_i is forwarded every cycle.
//   auto   (mode_i=1): the block walks circularly through the channels whose
//                      ch_mask_i bit is set, dwelling DWELL cycles on each.
//
// Ports:
//   clk          rising-edge system clock
//   rst_n        asynchronous active-low reset
//   en_i         clock enable; low freezes every register (wrap_o drops to 0)
//   mode_i       0 = manual select, 1 = auto-scan
//   sel_i        manual channel index
//   ch_mask_i    per-channel auto-scan eligibility
//   din_i        packed channel data, channel k at [k*WIDTH +: WIDTH]
//   dout_o       registered data of the current channel
//   onehot_o     registered one-hot of the current channel
//   cur_sel_o    registered current channel index
//   valid_o      dout_o holds data from a legal channel
//   wrap_o       one-cycle pulse when auto-scan wraps past the top channel
// -----------------------------------------------------------------------------
module scan_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic                      mode_i,
  input  logic [SEL_W-1:0]          sel_i,
  input  logic [CHANNELS-1:0]       ch_mask_i,
  input  logic [CHANNELS*WIDTH-1:0] din_i,
  output logic [WIDTH-1:0]          dout_o,
  output logic [CHANNELS-1:0]       onehot_o,
  output logic [SEL_W-1:0]          cur_sel_o,
  output logic                      valid_o,
  output logic                      wrap_o
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  // Lowest eligible channel reached by searching circularly upward from
  // base (inclusive). Returns -1 when no channel is eligible. The loop runs
  // from the largest offset down so the smallest offset is the one that sticks.
  function automatic int first_eligible(input logic [CHANNELS-1:0] mask,
                                        input int base);
    int result;
    int idx;
    result = -1;
    for (int off = CHANNELS - 1; off >= 0; off--) begin
      idx = base + off;
      if (idx >= CHANNELS) begin
        idx = idx - CHANNELS;
      end else begin
        idx = idx;
      end
      if (mask[idx]) begin
        result = idx;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [SEL_W-1:0]    cur_sel_q, cur_sel_d;
  logic [WIDTH-1:0]    dout_q,    dout_d;
  logic [CHANNELS-1:0] onehot_q,  onehot_d;
  logic                valid_q,   valid_d;
  logic                wrap_q,    wrap_d;
  // run_q: auto-scan currently owns an eligible channel. Cleared by reset,
  // manual mode and an empty mask, so the next auto cycle re-enters the scan
  // from cur_sel with a fresh dwell.
  logic                run_q,     run_d;

  int   pick_s;       // channel to present next cycle, -1 = none
  int   cur_s;
  int   sel_s;
  int   next_base_s;  // first index strictly above the current channel
  logic cur_elig_s;   // current channel still has its mask bit set

  // Next-state selection and output data path.
  always_comb begin
    cnt_d     = cnt_q;
    cur_sel_d = cur_sel_q;
    dout_d    = dout_q;
    onehot_d  = onehot_q;
    valid_d   = valid_q;
    wrap_d    = 1'b0;
    run_d     = run_q;
    pick_s    = -1;

    cur_s       = int'(cur_sel_q);
    sel_s       = int'(sel_i);
    next_base_s = (cur_s + 1 >= CHANNELS) ? 0 : cur_s + 1;

    cur_elig_s = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (k == cur_s) begin
        cur_elig_s = ch_mask_i[k];
      end else begin
        cur_elig_s = cur_elig_s;
      end
    end

    if (!en_i) begin
      // Frozen: every register keeps its value, only wrap is forced low.
      wrap_d = 1'b0;
    end else if (!mode_i) begin
      cur_sel_d = sel_i;
      pick_s    = (sel_s < CHANNELS) ? sel_s : -1;
      valid_d   = (pick_s >= 0);
      cnt_d     = {CNT_W{1'b0}};
      run_d     = 1'b0;
    end else if (ch_mask_i == {CHANNELS{1'b0}}) begin
      valid_d = 1'b0;
      cnt_d   = {CNT_W{1'b0}};
      run_d   = 1'b0;
    end else begin
      if (!run_q) begin
        // (Re)entry: stay on cur_sel if eligible, else step upward to the
        // next eligible channel. An out-of-range cur_sel searches from 0.
        pick_s = first_eligible(ch_mask_i, (cur_s < CHANNELS) ? cur_s : 0);
        cnt_d  = {CNT_W{1'b0}};
      end else if (!cur_elig_s || (cnt_q == CNT_LAST)) begin
        // Dwell expired or channel dropped: advance. A result at or below
        // the current index means the search went past the top channel,
        // which also covers the single-eligible-channel case.
        pick_s = first_eligible(ch_mask_i, next_base_s);
        wrap_d = (pick_s <= cur_s) ? 1'b1 : 1'b0;
        cnt_d  = {CNT_W{1'b0}};
      end else begin
        pick_s = cur_s;
        cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      cur_sel_d = SEL_W'(pick_s);
      valid_d   = 1'b1;
      run_d     = 1'b1;
    end

    if (en_i) begin
      dout_d   = {WIDTH{1'b0}};
      onehot_d = {CHANNELS{1'b0}};
      for (int k = 0; k < CHANNELS; k++) begin
        if (k == pick_s) begin
          dout_d      = din_i[k*WIDTH +: WIDTH];
          onehot_d[k] = 1'b1;
        end else begin
          onehot_d[k] = 1'b0;
        end
      end
    end else begin
      dout_d   = dout_q;
      onehot_d = onehot_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= {CNT_W{1'b0}};
      cur_sel_q <= {SEL_W{1'b0}};
      dout_q    <= {WIDTH{1'b0}};
      onehot_q  <= {CHANNELS{1'b0}};
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cur_sel_q <= cur_sel_d;
      dout_q    <= dout_d;
      onehot_q  <= onehot_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
      run_q     <= run_d;
    end
  end

  assign dout_o    = dout_q;
  assign onehot_o  = onehot_q;
  assign cur_sel_o = cur_sel_q;
  assign valid_o   = valid_q;
  assign wrap_o    = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_scan_mux -- self-checking bench for scan_mux.
// Two instances share the stimulus: a 4-channel block (DWELL=8) and a
// 3-channel block (DWELL=3) that exercises out-of-range manual selects.
// A behavioural model built on lists of eligible channels predicts every
// output each cycle.
// -----------------------------------------------------------------------------
module tb_scan_mux;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  mask;
  logic [15:0] din;

  logic [3:0]  d4_dout;
  logic [3:0]  d4_onehot;
  logic [1:0]  d4_cur_sel;
  logic        d4_valid;
  logic        d4_wrap;

  logic [3:0]  d3_dout;
  logic [2:0]  d3_onehot;
  logic [1:0]  d3_cur_sel;
  logic        d3_valid;
  logic        d3_wrap;

  int n_checks;
  int n_errors;

  scan_mux #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(8)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (en),
    .mode_i    (mode),
    .sel_i     (sel),
    .ch_mask_i (mask),
    .din_i     (din),
    .dout_o    (d4_dout),
    .onehot_o  (d4_onehot),
    .cur_sel_o (d4_cur_sel),
    .valid_o   (d4_valid),
    .wrap_o    (d4_wrap)
  );

  scan_mux #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (en),
    .mode_i    (mode),
    .sel_i     (sel),
    .ch_mask_i (mask[2:0]),
    .din_i     (din[11:0]),
    .dout_o    (d3_dout),
    .onehot_o  (d3_onehot),
    .cur_sel_o (d3_cur_sel),
    .valid_o   (d3_valid),
    .wrap_o    (d3_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  typedef struct {
    int sel;
    int cnt;
    bit run;
    int dout;
    int onehot;
    bit valid;
    bit wrap;
  } mstate_t;

  mstate_t m4;
  mstate_t m3;

  function automatic mstate_t mreset();
    mstate_t s;
    s.sel = 0; s.cnt = 0; s.run = 0; s.dout = 0; s.onehot = 0; s.valid = 0; s.wrap = 0;
    return s;
  endfunction

  function automatic int chunk(int data, int k);
    return (data >> (k * 4)) & 15;
  endfunction

  function automatic mstate_t mstep(mstate_t s, bit e, bit md, int sl, int mk,
                                    int data, int nch, int dwell);
    int  elig[$];
    int  tgt;
    bit  found;
    if (!e) begin
      s.wrap = 0;
      return s;
    end
    s.wrap = 0;
    if (!md) begin
      s.sel = sl; s.cnt = 0; s.run = 0;
      if (sl < nch) begin
        s.valid = 1; s.onehot = 1 << sl; s.dout = chunk(data, sl);
      end else begin
        s.valid = 0; s.onehot = 0; s.dout = 0;
      end
      return s;
    end
    for (int k = 0; k < nch; k++) if (((mk >> k) & 1) == 1) elig.push_back(k);
    if (elig.size() == 0) begin
      s.valid = 0; s.onehot = 0; s.dout = 0; s.cnt = 0; s.run = 0;
      return s;
    end
    if (!s.run) begin
      tgt = elig[0]; found = 0;
      foreach (elig[i]) if (!found && elig[i] >= s.sel) begin tgt = elig[i]; found = 1; end
      s.cnt = 0;
    end else if ((((mk >> s.sel) & 1) == 0) || (s.cnt == dwell - 1)) begin
      tgt = elig[0]; found = 0;
      foreach (elig[i]) if (!found && elig[i] > s.sel) begin tgt = elig[i]; found = 1; end
      s.wrap = !found;
      s.cnt = 0;
    end else begin
      tgt = s.sel;
      s.cnt = s.cnt + 1;
    end
    s.sel = tgt; s.run = 1; s.valid = 1; s.onehot = 1 << tgt; s.dout = chunk(data, tgt);
    return s;
  endfunction

  // ---------------------------------------------------------------- checks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("d4.dout",    32'(d4_dout),    32'(m4.dout));
    check("d4.onehot",  32'(d4_onehot),  32'(m4.onehot));
    check("d4.cur_sel", 32'(d4_cur_sel), 32'(m4.sel));
    check("d4.valid",   32'(d4_valid),   32'(m4.valid));
    check("d4.wrap",    32'(d4_wrap),    32'(m4.wrap));
    check("d3.dout",    32'(d3_dout),    32'(m3.dout));
    check("d3.onehot",  32'(d3_onehot),  32'(m3.onehot));
    check("d3.cur_sel", 32'(d3_cur_sel), 32'(m3.sel));
    check("d3.valid",   32'(d3_valid),   32'(m3.valid));
    check("d3.wrap",    32'(d3_wrap),    32'(m3.wrap));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m4 = mreset();
      m3 = mreset();
    end else begin
      m4 = mstep(m4, en, mode, int'(sel), int'(mask), int'(din), 4, 8);
      m3 = mstep(m3, en, mode, int'(sel), int'(mask) & 7, int'(din) & 32'h0fff, 3, 3);
    end
    #1;
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".d4"}, {19'd0, d4_dout, d4_onehot, d4_cur_sel, d4_valid, d4_wrap}, 32'd0);
    check({tag, ".d3"}, {20'd0, d3_dout, d3_onehot, d3_cur_sel, d3_valid, d3_wrap}, 32'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int wraps;
    logic [1:0] held_sel;
    logic [3:0] held_dout;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b1; en = 1'b1; mode = 1'b0; sel = 2'd0; mask = 4'd0; din = 16'd0;
    m4 = mreset();
    m3 = mreset();
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset_init");
    tick();
    rst_n = 1'b1;

    // Manual mode sweep.
    din = 16'hDCBA;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick();
      check("man.dout",   32'(d4_dout),   32'(10 + s));
      check("man.onehot", 32'(d4_onehot), 32'(1 << s));
    end
    check("man3.valid_oor", 32'(d3_valid), 32'd0);
    check("man3.dout_oor",  32'(d3_dout),  32'd0);

    // Auto, full mask: one wrap per 32-cycle period on the 4-channel block.
    mode = 1'b1; mask = 4'hF;
    for (int i = 0; i < 8; i++) tick();
    wraps = 0;
    for (int i = 0; i < 32; i++) begin
      din = 16'($urandom);
      tick();
      if (d4_wrap) wraps++;
    end
    check("auto.wrap_count", 32'(wraps), 32'd1);

    // Sparse mask, then empty, then a single restored channel.
    mask = 4'hA;
    for (int i = 0; i < 36; i++) begin din = 16'($urandom); tick(); end
    mask = 4'h0;
    tick();
    check("empty.valid", 32'(d4_valid), 32'd0);
    check("empty.dout",  32'(d4_dout),  32'd0);
    tick();
    mask = 4'h4;
    tick();
    check("restore.cur_sel", 32'(d4_cur_sel), 32'd2);
    check("restore.valid",   32'(d4_valid),   32'd1);

    // Enable hold mid-dwell.
    mask = 4'hF;
    for (int i = 0; i < 11; i++) tick();
    held_sel = d4_cur_sel; held_dout = d4_dout;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin din = 16'($urandom); tick(); end
    check("hold.cur_sel", 32'(d4_cur_sel), 32'(held_sel));
    check("hold.dout",    32'(d4_dout),    32'(held_dout));
    en = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    // Mode switching.
    mode = 1'b0; sel = 2'd2;
    tick();
    mode = 1'b1; mask = 4'hB;
    tick();
    check("m2a.cur_sel", 32'(d4_cur_sel), 32'd3);
    for (int i = 0; i < 4; i++) tick();
    mode = 1'b0; sel = 2'd1;
    tick();
    check("a2m.cur_sel", 32'(d4_cur_sel), 32'd1);

    // Reset in the middle of a scan, between edges.
    mode = 1'b1; mask = 4'hF;
    for (int i = 0; i < 5; i++) tick();
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid");
    m4 = mreset();
    m3 = mreset();
    tick();
    rst_n = 1'b1;
    tick();
    check("rel.cur_sel", 32'(d4_cur_sel), 32'd0);
    check("rel.valid",   32'(d4_valid),   32'd1);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      sel = 2'($urandom);
      din = 16'($urandom);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 24) == 0) mask = 4'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised, registered N-channel multiplexer with one-hot channel-select outputs. Successor to the 4:1 combinational mux/decoder block.
- Adds two modes: manual select, and an auto-scan mode that cycles through the enabled channels with a programmable dwell time.
- Sits between multi-channel sources (switch banks, sensor lines) and a single downstream consumer, such as a display driver or serial sink.

Parameters:
- WIDTH, 4, data bits per channel
- CHANNELS, 4, number of input channels (2..16)
- SEL_W, 2, select width; must satisfy 2**SEL_W >= CHANNELS
- DWELL, 8, clock cycles spent on each channel in auto mode (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  clock enable; low holds all state and outputs
- mode  in  1  0 = manual select, 1 = auto-scan
- sel  in  SEL_W  manual channel index
- ch_mask  in  CHANNELS  1 = channel eligible in auto-scan
- din  in  CHANNELS*WIDTH  packed inputs; channel k occupies bits [k*WIDTH +: WIDTH]
- dout  out  WIDTH  registered selected data
- onehot  out  CHANNELS  registered one-hot of the current channel
- cur_sel  out  SEL_W  registered current channel index
- valid  out  1  dout holds data from a legal channel
- wrap  out  1  one-cycle pulse when auto-scan wraps past the highest eligible channel

Behaviour:
- Reset (rst_n low, asynchronous): dout=0, onehot=0, cur_sel=0, valid=0, wrap=0, dwell counter=0.
- All outputs are registered and update only on a rising clk with en=1. With en=0, all state holds and wrap=0.

Manual mode (mode=0):
- Each cycle, cur_sel<=sel, dout<=din[sel], onehot<=1<<sel, valid<=1. Latency is 1 cycle from sel/din to dout.
- If sel>=CHANNELS: dout<=0, onehot<=0, valid<=0, and cur_sel<=sel.
- ch_mask is ignored in manual mode.

Auto mode (mode=1):
- The dwell counter counts 0..DWELL-1.
- While the counter is below DWELL-1: the counter increments and the channel holds. dout tracks din of the held channel every cycle.
- When the counter reaches DWELL-1: the counter returns to 0 and cur_sel advances to the next index above it with ch_mask=1, searching circularly.
- If the search passes index CHANNELS-1 to reach the new channel, wrap=1 for that one cycle.
- If the current channel is the only eligible channel, it stays selected, and wrap pulses on each dwell expiry.
- If ch_mask=0 (no eligible channels): valid<=0, dout<=0, onehot<=0, and cur_sel holds.
- When a mask bit returns to 1: on the next cycle, selection jumps to the lowest eligible index at or above cur_sel, searching circularly, and the counter restarts at 0.
- If the current channel's mask bit is cleared mid-dwell: selection advances on the next cycle without waiting for the dwell to expire.

Mode changes:
- Manual->auto: the first auto cycle starts from the current cur_sel. If that channel is ineligible or out of range, it steps to the next eligible channel. The counter is cleared.
- Auto->manual: takes effect on the next edge; the counter is cleared.

Other rules:
- Reset asserted mid-scan forces all outputs to their reset values immediately. After release, scanning restarts from channel 0.
- valid=1 in auto mode whenever an eligible channel is selected.
- wrap is 0 in manual mode.

Test Plan:
- Reset: rst_n=0 mid-operation, between clock edges -> all outputs 0 immediately. After release with mode=1 and ch_mask=4'b1111 -> cur_sel=0 and valid=1 after the first edge.
- Manual: din={4'hD,4'hC,4'hB,4'hA}, step sel through 0..3 -> one cycle later, dout=A,B,C,D and onehot=0001,0010,0100,1000. With CHANNELS=3 and sel=3 -> valid=0, dout=0.
- Auto full mask: DWELL=8, ch_mask=1111 -> cur_sel sequence 0,1,2,3,0 with each value held exactly 8 cycles. wrap pulses for exactly one cycle at each 3->0 transition.
- Auto sparse mask: ch_mask=1010 -> cur_sel alternates 1,3,1,3. wrap pulses at each 3->1. Set ch_mask=0000 -> valid=0, dout=0 the next cycle. Restore ch_mask=0100 -> cur_sel=2 and valid=1.
- Enable hold: en=0 for 5 cycles mid-dwell -> dout, cur_sel and counter frozen. After en returns to 1, the remaining dwell cycles complete before the next advance.
- Mode switch: manual with sel=2, then mode=1 with ch_mask=1011 -> cur_sel goes to 3, counter cleared. Switch back to mode=0 with sel=1 -> cur_sel=1 on the next edge.
